// File: rtl/fake_netlist_vector_driver.sv
// Serial-to-parallel stimulus driver for fake netlists: assembles byte chunks into a vector,
// applies it, waits a settle window and returns the sampled output bit. MISR: FAKE_NETLIST_VECDRV_MISR_EN.
module fake_netlist_vector_driver #(
   parameter int NUM_IN     = 355,
   parameter int CHUNK_W    = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ser_valid_i,
   input  logic [CHUNK_W-1:0] ser_data_i,
   output logic               ser_ready_o,
   output logic [NUM_IN-1:0]  vec_o,
   input  logic               resp_bit_i,
   output logic               resp_valid_o,
   output logic               resp_o,
   output logic [15:0]        resp_tag_o,
   input  logic               resp_ready_i,
   output logic [31:0]        sig_o
);
   // state  | meaning
   // LOAD   | accepting chunks into stg; vec_o holds previous vector
   // SETTLE | new vector applied, counting down the settle window
   // RESP   | sampled bit presented on the response port
   localparam int NCHUNK = (NUM_IN + CHUNK_W - 1) / CHUNK_W;
   localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CNT_W  = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {LOAD, SETTLE, RESP} state_t;

   state_t              state;
   logic [CIDX_W-1:0]   chunk_idx;
   logic [CNT_W-1:0]    settle_cnt;
   logic [NUM_IN-1:0]   stg;
   logic [NUM_IN-1:0]   stg_next;
   logic [NUM_IN-1:0]   data_ext;
   logic [NUM_IN-1:0]   chunk_mask;
   logic [15:0]         shamt;
   logic                last_chunk;

   // Bits of the final chunk beyond NUM_IN fall off the top of the shift.
   always_comb begin
      shamt      = 16'(chunk_idx) * 16'(CHUNK_W);
      data_ext   = {{(NUM_IN-CHUNK_W){1'b0}}, ser_data_i};
      chunk_mask = {{(NUM_IN-CHUNK_W){1'b0}}, {CHUNK_W{1'b1}}};
      stg_next   = (stg & ~(chunk_mask << shamt)) | (data_ext << shamt);
      last_chunk = (chunk_idx == CIDX_W'(NCHUNK - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= LOAD;
         chunk_idx    <= '0;
         settle_cnt   <= '0;
         stg          <= '0;
         vec_o        <= '0;
         ser_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_o       <= 1'b0;
         resp_tag_o   <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (ser_valid_i) begin
                  stg <= stg_next;
                  if (last_chunk) begin
                     vec_o       <= stg_next;
                     chunk_idx   <= '0;
                     settle_cnt  <= CNT_W'(SETTLE_CYC);
                     ser_ready_o <= 1'b0;
                     state       <= SETTLE;
                  end else begin
                     chunk_idx <= chunk_idx + CIDX_W'(1);
                  end
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
               if (settle_cnt == CNT_W'(1)) begin
                  resp_o       <= resp_bit_i;
                  resp_valid_o <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  ser_ready_o  <= 1'b1;
                  resp_tag_o   <= resp_tag_o + 16'd1;
                  state        <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

`ifdef FAKE_NETLIST_VECDRV_MISR_EN
   logic [31:0] sig;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig <= 32'hFFFF_FFFF;
      end else if (resp_valid_o && resp_ready_i) begin
         sig <= ({sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)) ^ {31'b0, resp_o};
      end
   end

   assign sig_o = sig;
`else
   assign sig_o = 32'h0;
`endif

endmodule
